// File: rtl/instruction_memory.sv
// -----------------------------------------------------------------------------
// instruction_memory
//
// Block-oriented instruction memory serving an instruction cache. A single
// word store of 256 x 32 bits is read as 64 four-word blocks. Each read request
// is accepted, held for LATENCY clock edges and then delivered as one 128-bit
// block. The busywait handshake is combinational, so the cache stalls on the
// very edge at which it first raises mem_read. A separate loader port writes
// single words at any time.
//
// Parameters
//   LATENCY         edges from request acceptance to block delivery (1..15)
//
// Ports
//   clock           single clock; all state changes on the rising edge
//   reset           asynchronous, active-low reset (memory array is kept)
//   mem_read        cache block-read request, held until the block is captured
//   mem_address     block address; block b holds words 4b..4b+3
//   mem_readdata    delivered block; word 4b+k on bits [32k+31:32k]
//   mem_busywait    stall to the cache; low means mem_readdata is valid
//   prog_write      loader word write enable
//   prog_address    loader word index 0..255
//   prog_writedata  loader write data
// -----------------------------------------------------------------------------
module instruction_memory #(
    parameter int unsigned LATENCY = 5
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         mem_read,
    input  logic [5:0]   mem_address,
    output logic [127:0] mem_readdata,
    output logic         mem_busywait,
    input  logic         prog_write,
    input  logic [7:0]   prog_address,
    input  logic [31:0]  prog_writedata
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RELEASE
    } state_t;

    localparam logic [3:0] LAT = 4'(LATENCY);

    state_t      state, state_next;
    logic [3:0]  count, count_next;
    logic [5:0]  block, block_next;
    logic        deliver;

    logic [31:0] mem [256];

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        count_next = count;
        block_next = block;
        deliver    = 1'b0;
        case (state)
            IDLE: begin
                if (mem_read) begin
                    state_next = BUSY;
                    count_next = 4'd1;
                    block_next = mem_address;
                end
            end
            BUSY: begin
                if (!mem_read) begin
                    // The cache gave up on the request: abort without delivering.
                    state_next = IDLE;
                    count_next = 4'd0;
                end else if (count == LAT) begin
                    deliver    = 1'b1;
                    state_next = RELEASE;
                end else begin
                    count_next = count + 4'd1;
                end
            end
            RELEASE: begin
                // Stay here while mem_read is still high so that a request the
                // cache has not yet lowered is not served a second time.
                if (!mem_read) begin
                    state_next = IDLE;
                    count_next = 4'd0;
                end
            end
            default: begin
                state_next = IDLE;
                count_next = 4'd0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, including the memory words read on delivery.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            count        <= 4'd0;
            block        <= 6'd0;
            mem_readdata <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            block <= block_next;
            if (deliver) begin
                // A loader write on this same edge is not yet visible here.
                mem_readdata <= {mem[{block, 2'd3}], mem[{block, 2'd2}],
                                 mem[{block, 2'd1}], mem[{block, 2'd0}]};
            end
        end
    end

    // NOTE: the storage array has no reset; program contents must survive a
    // reset, and leaving it out keeps the array mappable onto RAM.
    always_ff @(posedge clock) begin
        if (prog_write) begin
            mem[prog_address] <= prog_writedata;
        end
    end

    // Busy from the moment a request is presented in IDLE, so the cache never
    // captures stale data on its first request edge. Forced low during reset.
    assign mem_busywait = reset && (((state == IDLE) && mem_read) || (state == BUSY));

endmodule

// File: tb/tb_instruction_memory.sv
// -----------------------------------------------------------------------------
// tb_instruction_memory
//
// Directed bench for instruction_memory. One instance uses LATENCY=5, a second
// uses LATENCY=1; both share clock, reset and the loader port. Inputs change on
// the falling edge and outputs are sampled there as well.
// -----------------------------------------------------------------------------
module tb_instruction_memory;

    logic         clock;
    logic         reset;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readdata;
    logic         mem_busywait;
    logic         read1;
    logic [5:0]   address1;
    logic [127:0] readdata1;
    logic         busywait1;
    logic         prog_write;
    logic [7:0]   prog_address;
    logic [31:0]  prog_writedata;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [127:0] B1     = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    localparam logic [127:0] B9     = {32'h90000003, 32'h90000002, 32'h90000001, 32'h90000000};
    localparam logic [127:0] B1_NEW = {32'h44444444, 32'h33333333, 32'h22222222, 32'hDEADBEEF};

    instruction_memory #(.LATENCY(5)) dut (
        .clock          (clock),
        .reset          (reset),
        .mem_read       (mem_read),
        .mem_address    (mem_address),
        .mem_readdata   (mem_readdata),
        .mem_busywait   (mem_busywait),
        .prog_write     (prog_write),
        .prog_address   (prog_address),
        .prog_writedata (prog_writedata)
    );

    instruction_memory #(.LATENCY(1)) dut1 (
        .clock          (clock),
        .reset          (reset),
        .mem_read       (read1),
        .mem_address    (address1),
        .mem_readdata   (readdata1),
        .mem_busywait   (busywait1),
        .prog_write     (prog_write),
        .prog_address   (prog_address),
        .prog_writedata (prog_writedata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Starts a request on the LATENCY=5 instance; must be called just after a
    // falling edge. Optional actions per busy cycle i (1-based): change the
    // address, drop mem_read, or issue one loader write. Leaves mem_read as is.
    task automatic do_fetch(input logic [5:0] addr,
                            input int chg_cycle, input logic [5:0] chg_addr,
                            input int drop_cycle,
                            input int wr_cycle, input logic [7:0] wr_addr,
                            input logic [31:0] wr_data,
                            output int busy_cnt);
        busy_cnt    = 0;
        mem_read    = 1'b1;
        mem_address = addr;
        #1;
        n_checks++;
        if (mem_busywait !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_busywait: got %b want 1", mem_busywait);
        end
        for (int i = 1; i <= 30; i++) begin
            @(negedge clock);
            prog_write = 1'b0;
            if (mem_busywait !== 1'b1) break;
            busy_cnt++;
            if (i == chg_cycle)  mem_address = chg_addr;
            if (i == drop_cycle) mem_read = 1'b0;
            if (i == wr_cycle) begin
                prog_write     = 1'b1;
                prog_address   = wr_addr;
                prog_writedata = wr_data;
            end
            if (i == 30) begin
                n_checks++;
                n_fail++;
                $display("FAIL fetch_timeout: busywait still %b after %0d cycles", mem_busywait, i);
            end
        end
    endtask

    task automatic drop_read();
        mem_read = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        mem_read = 1'b1;
        read1    = 1'b1;
        #2;
        n_checks++;
        if (mem_busywait !== 1'b0) begin
            n_fail++; $display("FAIL reset_busywait: got %b want 0", mem_busywait);
        end
        n_checks++;
        if (mem_readdata !== 128'h0) begin
            n_fail++; $display("FAIL reset_readdata: got %h want 0", mem_readdata);
        end
        n_checks++;
        if (busywait1 !== 1'b0 || readdata1 !== 128'h0) begin
            n_fail++; $display("FAIL reset_lat1: busywait %b data %h want 0 and 0", busywait1, readdata1);
        end
        @(negedge clock);
        mem_read = 1'b0;
        read1    = 1'b0;
        reset    = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_load();
        logic [31:0] words [8];
        logic [7:0]  addrs [8];
        words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                  32'h90000000, 32'h90000001, 32'h90000002, 32'h90000003};
        addrs = '{8'd4, 8'd5, 8'd6, 8'd7, 8'd36, 8'd37, 8'd38, 8'd39};
        for (int i = 0; i < 8; i++) begin
            prog_write     = 1'b1;
            prog_address   = addrs[i];
            prog_writedata = words[i];
            @(negedge clock);
        end
        prog_write = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_basic_fetch();
        int cnt;
        do_fetch(6'd1, 0, 6'd0, 0, 0, 8'd0, 32'd0, cnt);
        n_checks++;
        if (cnt != 5) begin
            n_fail++; $display("FAIL basic_busy_len: got %0d want 5", cnt);
        end
        n_checks++;
        if (mem_readdata !== B1) begin
            n_fail++; $display("FAIL basic_data: got %h want %h", mem_readdata, B1);
        end
    endtask

    task automatic test_release_hold();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_checks++;
            if (mem_busywait !== 1'b0 || mem_readdata !== B1) begin
                n_fail++;
                $display("FAIL hold_%0d: busywait %b data %h want 0 and %h", i, mem_busywait, mem_readdata, B1);
            end
        end
        drop_read();
        n_checks++;
        if (mem_busywait !== 1'b0 || mem_readdata !== B1) begin
            n_fail++; $display("FAIL after_drop: busywait %b data %h want 0 and %h", mem_busywait, mem_readdata, B1);
        end
        // Only IDLE raises busywait combinationally for a fresh request.
        mem_read = 1'b1;
        #1;
        n_checks++;
        if (mem_busywait !== 1'b1) begin
            n_fail++; $display("FAIL idle_after_drop: busywait %b want 1", mem_busywait);
        end
        mem_read = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_back_to_back();
        int cnt;
        do_fetch(6'd9, 0, 6'd0, 0, 0, 8'd0, 32'd0, cnt);
        n_checks++;
        if (cnt != 5 || mem_readdata !== B9) begin
            n_fail++; $display("FAIL b2b_block9: busy %0d data %h want 5 and %h", cnt, mem_readdata, B9);
        end
        drop_read();
    endtask

    task automatic test_addr_change();
        int cnt;
        do_fetch(6'd1, 2, 6'd9, 0, 0, 8'd0, 32'd0, cnt);
        n_checks++;
        if (cnt != 5 || mem_readdata !== B1) begin
            n_fail++; $display("FAIL addr_change: busy %0d data %h want 5 and %h", cnt, mem_readdata, B1);
        end
        drop_read();
    endtask

    task automatic test_abort();
        int cnt;
        do_fetch(6'd9, 0, 6'd0, 3, 0, 8'd0, 32'd0, cnt);
        n_checks++;
        if (cnt != 3) begin
            n_fail++; $display("FAIL abort_len: got %0d want 3", cnt);
        end
        n_checks++;
        if (mem_busywait !== 1'b0 || mem_readdata !== B1) begin
            n_fail++; $display("FAIL abort_data: busywait %b data %h want 0 and %h", mem_busywait, mem_readdata, B1);
        end
        @(negedge clock);
    endtask

    task automatic test_reset_mid_busy();
        int cnt;
        mem_read    = 1'b1;
        mem_address = 6'd9;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        n_checks++;
        if (mem_busywait !== 1'b0 || mem_readdata !== 128'h0) begin
            n_fail++; $display("FAIL reset_mid_busy: busywait %b data %h want 0 and 0", mem_busywait, mem_readdata);
        end
        @(negedge clock);
        reset = 1'b1;
        do_fetch(6'd9, 0, 6'd0, 0, 0, 8'd0, 32'd0, cnt);
        n_checks++;
        if (cnt != 5 || mem_readdata !== B9) begin
            n_fail++; $display("FAIL refetch_after_reset: busy %0d data %h want 5 and %h", cnt, mem_readdata, B9);
        end
        drop_read();
    endtask

    task automatic test_write_on_delivery();
        int cnt;
        do_fetch(6'd1, 0, 6'd0, 0, 5, 8'd4, 32'hDEADBEEF, cnt);
        n_checks++;
        if (cnt != 5 || mem_readdata !== B1) begin
            n_fail++; $display("FAIL write_on_delivery: busy %0d data %h want 5 and %h", cnt, mem_readdata, B1);
        end
        drop_read();
        do_fetch(6'd1, 0, 6'd0, 0, 0, 8'd0, 32'd0, cnt);
        n_checks++;
        if (mem_readdata !== B1_NEW) begin
            n_fail++; $display("FAIL write_seen_next: got %h want %h", mem_readdata, B1_NEW);
        end
        drop_read();
    endtask

    task automatic fetch_lat1(input logic [5:0] addr, input logic [127:0] exp);
        int cnt;
        cnt      = 0;
        read1    = 1'b1;
        address1 = addr;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (busywait1 !== 1'b1) break;
            cnt++;
        end
        n_checks++;
        if (cnt != 1 || readdata1 !== exp) begin
            n_fail++; $display("FAIL lat1_block%0d: busy %0d data %h want 1 and %h", addr, cnt, readdata1, exp);
        end
        read1 = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_latency_one();
        fetch_lat1(6'd9, B9);
        fetch_lat1(6'd1, B1_NEW);
    endtask

    initial begin
        mem_read       = 1'b0;
        mem_address    = 6'd0;
        read1          = 1'b0;
        address1       = 6'd0;
        prog_write     = 1'b0;
        prog_address   = 8'd0;
        prog_writedata = 32'd0;
        test_reset();
        test_load();
        test_basic_fetch();
        test_release_hold();
        test_back_to_back();
        test_addr_change();
        test_abort();
        test_reset_mid_busy();
        test_write_on_delivery();
        test_latency_one();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
